// File: rtl/laa_ins_sequencer.sv
// rtl/laa_ins_sequencer.sv - script replay sequencer for the base and LAA instruction paths
//
// Replays a loaded FIFO of instruction words into the core's base path
// (ins_out) and large-arithmetic-accelerator path (laa_ins_out). It inserts
// hazard NOPs after base-path bursts and can re-issue a poll entry until the
// accelerator reports not-busy.
//
// Ports:
//   clk          system clock, rising edge
//   Rst          asynchronous active-high reset
//   wr_en        push one script entry (IDLE only, dropped otherwise)
//   wr_data      instruction word of the entry
//   wr_kind      0=base, 1=LAA, 2=LAA-poll, 3=reserved (LAA)
//   full         FIFO holds DEPTH entries
//   level        current FIFO occupancy
//   start        begin replay (sampled only in IDLE)
//   laa_busy_in  accelerator busy status
//   ins_out      registered base-path instruction
//   laa_ins_out  registered LAA-path instruction
//   busy         sequencer not in IDLE
//   done         one-cycle pulse in the DONE state
//   overflow     sticky: a write was dropped
//   timeout      sticky: a poll entry reached POLL_MAX issues
module laa_ins_sequencer #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 16,
    parameter int               NOP_GAP  = 6,
    parameter int               POLL_MAX = 16,
    parameter logic [XLEN-1:0]  NOP_WORD = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       Rst,
    input  logic                       wr_en,
    input  logic [XLEN-1:0]            wr_data,
    input  logic [1:0]                 wr_kind,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       start,
    input  logic                       laa_busy_in,
    output logic [XLEN-1:0]            ins_out,
    output logic [XLEN-1:0]            laa_ins_out,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic                       timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(POLL_MAX + 1);

    localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);
    localparam bit            GAP_EN     = (NOP_GAP > 0);
    localparam logic [3:0]    GAP_LAST   = (NOP_GAP > 0) ? 4'(NOP_GAP - 1) : 4'd0;

    localparam logic [1:0] KIND_BASE = 2'd0;
    localparam logic [1:0] KIND_POLL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_POLL,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XLEN-1:0] word_mem [DEPTH];
    logic [1:0]      kind_mem [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_next;

    logic [3:0]      gap_cnt;
    logic [PW-1:0]   poll_cnt;
    logic [XLEN-1:0] poll_word;

    logic [XLEN-1:0] ins_nxt;
    logic [XLEN-1:0] laa_nxt;
    logic            push;
    logic            drop;
    logic            pop;
    logic            start_acc;
    logic            poll_load;
    logic            poll_inc;
    logic            set_timeout;
    logic            last_entry;
    logic [XLEN-1:0] head_word;
    logic [1:0]      head_kind;
    logic [1:0]      next_kind;

    assign full        = (level == LW'(DEPTH));
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    assign push        = wr_en && (state == S_IDLE) && !full;
    assign drop        = wr_en && !push;
    assign start_acc   = start && (state == S_IDLE);

    assign rd_ptr_next = rd_ptr + AW'(1);
    assign head_word   = word_mem[rd_ptr];
    assign head_kind   = kind_mem[rd_ptr];
    // Kind of the entry behind the head; only meaningful while it exists.
    assign next_kind   = kind_mem[rd_ptr_next];
    assign last_entry  = (level == LW'(1));

    always_comb begin
        state_nxt   = state;
        ins_nxt     = '0;
        laa_nxt     = '0;
        pop         = 1'b0;
        poll_load   = 1'b0;
        poll_inc    = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (level != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (level == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    pop = 1'b1;
                    case (head_kind)
                        KIND_BASE: begin
                            ins_nxt = head_word;
                            // A burst ends when the script runs out or switches path.
                            if (GAP_EN && (last_entry || next_kind != KIND_BASE)) begin
                                state_nxt = S_GAP;
                            end else begin
                                state_nxt = last_entry ? S_DONE : S_ISSUE;
                            end
                        end
                        KIND_POLL: begin
                            laa_nxt   = head_word;
                            poll_load = 1'b1;
                            state_nxt = S_POLL;
                        end
                        default: begin
                            laa_nxt   = head_word;
                            state_nxt = last_entry ? S_DONE : S_ISSUE;
                        end
                    endcase
                end
            end
            S_GAP: begin
                ins_nxt = NOP_WORD;
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = (level == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_POLL: begin
                if (laa_busy_in && (poll_cnt < POLL_LIMIT)) begin
                    laa_nxt  = poll_word;
                    poll_inc = 1'b1;
                end else begin
                    set_timeout = laa_busy_in;
                    state_nxt   = (level == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state       <= S_IDLE;
            ins_out     <= '0;
            laa_ins_out <= '0;
        end else begin
            state       <= state_nxt;
            ins_out     <= ins_nxt;
            laa_ins_out <= laa_nxt;
        end
    end

    // Script storage needs no reset: pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= wr_data;
            kind_mem[wr_ptr] <= wr_kind;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_next;
            end
            // Pushes happen only in IDLE and pops only in ISSUE, never together.
            if (push) begin
                level <= level + LW'(1);
            end else if (pop) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            gap_cnt   <= '0;
            poll_cnt  <= '0;
            poll_word <= '0;
        end else begin
            gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (poll_load) begin
                poll_cnt  <= PW'(1);
                poll_word <= head_word;
            end else if (poll_inc) begin
                poll_cnt <= poll_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (start_acc) begin
                overflow <= 1'b0;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end else if (start_acc) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_laa_ins_sequencer.sv
// tb/tb_laa_ins_sequencer.sv - scoreboard bench for laa_ins_sequencer
module tb_laa_ins_sequencer;

    logic        clk = 1'b0;
    logic        Rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [1:0]  wr_kind;
    logic        start;
    logic        laa_busy_in;
    logic        sel;

    logic        full_a, busy_a, done_a, ovf_a, to_a;
    logic [4:0]  level_a;
    logic [31:0] ins_a, laa_a;
    logic        full_b, busy_b, done_b, ovf_b, to_b;
    logic [4:0]  level_b;
    logic [31:0] ins_b, laa_b;

    logic [31:0] obs_ins, obs_laa;
    logic        obs_done, obs_busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] laa;
        logic        done;
        logic        busy;
        logic        bz;
    } cyc_t;

    cyc_t expq[$];

    always #5 clk = ~clk;

    laa_ins_sequencer dut_a (
        .clk(clk), .Rst(Rst),
        .wr_en(wr_en && !sel), .wr_data(wr_data), .wr_kind(wr_kind),
        .full(full_a), .level(level_a),
        .start(start && !sel), .laa_busy_in(laa_busy_in),
        .ins_out(ins_a), .laa_ins_out(laa_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .timeout(to_a)
    );

    laa_ins_sequencer #(.NOP_GAP(0)) dut_b (
        .clk(clk), .Rst(Rst),
        .wr_en(wr_en && sel), .wr_data(wr_data), .wr_kind(wr_kind),
        .full(full_b), .level(level_b),
        .start(start && sel), .laa_busy_in(laa_busy_in),
        .ins_out(ins_b), .laa_ins_out(laa_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .timeout(to_b)
    );

    assign obs_ins  = sel ? ins_b  : ins_a;
    assign obs_laa  = sel ? laa_b  : laa_a;
    assign obs_done = sel ? done_b : done_a;
    assign obs_busy = sel ? busy_b : busy_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_cyc(input logic [31:0] ins, input logic [31:0] laa,
                            input logic dn, input logic bs, input logic bz);
        cyc_t c;
        c.ins = ins; c.laa = laa; c.done = dn; c.busy = bs; c.bz = bz;
        expq.push_back(c);
    endtask

    task automatic write_entry(input logic [1:0] kind, input logic [31:0] data);
        wr_en = 1'b1; wr_kind = kind; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_queue(input string tag);
        cyc_t e;
        int k = 0;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            laa_busy_in = e.bz;
            @(negedge clk);
            chk($sformatf("%s.ins[%0d]", tag, k),  obs_ins,  e.ins);
            chk($sformatf("%s.laa[%0d]", tag, k),  obs_laa,  e.laa);
            chk($sformatf("%s.done[%0d]", tag, k), 32'(obs_done), 32'(e.done));
            chk($sformatf("%s.busy[%0d]", tag, k), 32'(obs_busy), 32'(e.busy));
            chk($sformatf("%s.excl[%0d]", tag, k),
                32'(obs_ins != 0 && obs_laa != 0), 32'd0);
            @(posedge clk); #1;
            k++;
        end
        laa_busy_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_kind = '0;
        start = 1'b0; laa_busy_in = 1'b0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ins", ins_a, 32'd0);
        chk("rst.laa", laa_a, 32'd0);
        chk("rst.level", 32'(level_a), 32'd0);
        chk("rst.busy", 32'(busy_a), 32'd0);
        chk("rst.done", 32'(done_a), 32'd0);
        chk("rst.ovf", 32'(ovf_a), 32'd0);
        chk("rst.to", 32'(to_a), 32'd0);
        @(negedge clk); Rst = 1'b0;
        @(posedge clk); #1;
        chk("idle.full", 32'(full_a), 32'd0);

        // Base then LAA: one base word, six NOPs, then the LAA word.
        write_entry(2'd0, 32'h000017b7);
        write_entry(2'd1, 32'h7800010B);
        chk("t1.level", 32'(level_a), 32'd2);
        do_start();
        push_cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        push_cyc(32'h000017b7, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) push_cyc(32'h00000013, 32'h0, 1'b0, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h7800010B, 1'b1, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_queue("t1");

        // Poll released after five busy cycles: six issues, no timeout.
        write_entry(2'd1, 32'h7A40010B);
        write_entry(2'd1, 32'h0000018B);
        write_entry(2'd2, 32'h7FC0008B);
        do_start();
        push_cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h7A40010B, 1'b0, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h0000018B, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            push_cyc(32'h0, 32'h7FC0008B, 1'b0, 1'b1, (i < 5) ? 1'b1 : 1'b0);
        push_cyc(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_queue("t2");
        chk("t2.timeout", 32'(to_a), 32'd0);

        // Poll stuck busy: exactly sixteen issues, then timeout.
        write_entry(2'd2, 32'h7FC0008B);
        do_start();
        push_cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) push_cyc(32'h0, 32'h7FC0008B, 1'b0, 1'b1, 1'b1);
        push_cyc(32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        push_cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_queue("t3");
        chk("t3.timeout", 32'(to_a), 32'd1);
        do_start();
        push_cyc(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_queue("t3b");
        chk("t3.to_clr", 32'(to_a), 32'd0);

        // Seventeen writes: sixteen stored, the last one dropped.
        for (int i = 0; i < 16; i++) write_entry(2'd1, 32'h10000000 + 32'(i));
        chk("t4.full", 32'(full_a), 32'd1);
        chk("t4.level16", 32'(level_a), 32'd16);
        chk("t4.ovf0", 32'(ovf_a), 32'd0);
        write_entry(2'd1, 32'hDEADBEEF);
        chk("t4.ovf1", 32'(ovf_a), 32'd1);
        chk("t4.level17", 32'(level_a), 32'd16);
        do_start();
        push_cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++)
            push_cyc(32'h0, 32'h10000000 + 32'(i), (i == 15), 1'b1, 1'b0);
        push_cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_queue("t4");
        chk("t4.ovf_clr", 32'(ovf_a), 32'd0);
        chk("t4.empty", 32'(level_a), 32'd0);

        // Reset in the middle of a base burst.
        for (int i = 0; i < 4; i++) write_entry(2'd0, 32'h00000100 + 32'(i));
        do_start();
        push_cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        push_cyc(32'h00000100, 32'h0, 1'b0, 1'b1, 1'b0);
        run_queue("t5");
        chk("t5.ins_b1", ins_a, 32'h00000101);
        Rst = 1'b1;
        #1;
        chk("t5.rst_ins", ins_a, 32'd0);
        chk("t5.rst_laa", laa_a, 32'd0);
        chk("t5.rst_busy", 32'(busy_a), 32'd0);
        chk("t5.rst_level", 32'(level_a), 32'd0);
        @(negedge clk); Rst = 1'b0;
        @(posedge clk); #1;
        do_start();
        push_cyc(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_queue("t5b");

        // Zero-gap build: base and LAA issue on consecutive cycles.
        sel = 1'b1;
        write_entry(2'd0, 32'hef478793);
        write_entry(2'd1, 32'h7800008B);
        chk("t6.level", 32'(level_b), 32'd2);
        do_start();
        push_cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        push_cyc(32'hef478793, 32'h0, 1'b0, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h7800008B, 1'b1, 1'b1, 1'b0);
        push_cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_queue("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
